// File: rtl/l2_tag_pkg.sv
// Shared types for the L2 tag array: per-way entry layout, FSM states and
// the priority helper used to turn a hit vector into a way number.
package l2_tag_pkg;

  localparam int L2_TAG_W = 23;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [L2_TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowest_set(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/l2_tag_way.sv
// One way of the tag store: NUM_SETS entries, registered read, write with
// same-cycle bypass, and a valid/dirty-only clear port for the sweep.
module l2_tag_way
  import l2_tag_pkg::*;
#(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [S_INDEX-1:0] rindex,
  input  logic               wr_en,
  input  logic [S_INDEX-1:0] windex,
  input  tag_entry_t         wr_entry,
  input  logic               clr_en,
  input  logic [S_INDEX-1:0] clr_index,
  output tag_entry_t         rd_entry
);

  localparam int NUM_SETS = 2 ** S_INDEX;

  tag_entry_t mem [NUM_SETS];

  // Storage has no reset so it can map onto RAM; the sweep keeps tags intact.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_index].valid <= 1'b0;
      mem[clr_index].dirty <= 1'b0;
    end else if (wr_en) begin
      mem[windex] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_entry <= '0;
    end else if (rd_en) begin
      rd_entry <= (wr_en && (windex == rindex)) ? wr_entry : mem[rindex];
    end
  end

endmodule

// File: rtl/l2_tag_array_nway.sv
// N-way L2 tag/valid/dirty array: init/flush sweep FSM, 1-cycle registered
// read of all ways, masked write with bypass, and hit vector / hit way.
module l2_tag_array_nway
  import l2_tag_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 4,
  parameter int TAG_W   = L2_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ready,
  input  logic                     read,
  input  logic [S_INDEX-1:0]       rindex,
  input  logic [TAG_W-1:0]         ctag,
  input  logic                     load,
  input  logic [S_INDEX-1:0]       windex,
  input  logic [WAYS-1:0]          wmask,
  input  logic [TAG_W-1:0]         wtag,
  input  logic                     wvalid,
  input  logic                     wdirty,
  output logic                     rvalid,
  output logic [WAYS*TAG_W-1:0]    rtag,
  output logic [WAYS-1:0]          rvalid_bits,
  output logic [WAYS-1:0]          rdirty_bits,
  output logic [WAYS-1:0]          hit_vec,
  output logic                     hit,
  output logic [$clog2(WAYS)-1:0]  hit_way,
  input  logic                     flush_req,
  output logic                     flush_done
);

  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int WAY_W    = $clog2(WAYS);

  state_t             state;
  logic [S_INDEX-1:0] cnt;
  logic               sweep;
  logic               last_set;
  logic               rd_acc;
  logic               wr_acc;
  logic [TAG_W-1:0]   ctag_q;
  tag_entry_t         wr_entry;
  tag_entry_t         rd_e [WAYS];

  assign ready    = (state == ST_IDLE);
  assign sweep    = (state == ST_INIT) || (state == ST_FLUSH);
  assign last_set = (cnt == S_INDEX'(NUM_SETS - 1));
  assign rd_acc   = read && ready;
  assign wr_acc   = load && ready;

  // Only a completed flush is reported; the power-up sweep stays silent.
  assign flush_done = (state == ST_FLUSH) && last_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state <= ST_FLUSH;
            cnt   <= '0;
          end
        end
        ST_INIT, ST_FLUSH: begin
          cnt <= cnt + 1'b1;
          if (last_set) state <= ST_IDLE;
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      ctag_q <= '0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc) ctag_q <= ctag;
    end
  end

  assign wr_entry = '{valid: wvalid, dirty: wdirty, tag: wtag};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    l2_tag_way #(
      .S_INDEX (S_INDEX)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_acc),
      .rindex    (rindex),
      .wr_en     (wr_acc && wmask[w]),
      .windex    (windex),
      .wr_entry  (wr_entry),
      .clr_en    (sweep),
      .clr_index (cnt),
      .rd_entry  (rd_e[w])
    );

    // Compare works on the registered entry and registered ctag, so the hit
    // outputs hold alongside the data between reads.
    assign rtag[w*TAG_W +: TAG_W] = rd_e[w].tag;
    assign rvalid_bits[w]         = rd_e[w].valid;
    assign rdirty_bits[w]         = rd_e[w].dirty;
    assign hit_vec[w]             = rd_e[w].valid && (rd_e[w].tag == ctag_q);
  end

  assign hit     = |hit_vec;
  assign hit_way = WAY_W'(lowest_set(32'(hit_vec)));

endmodule
